// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset vector and fetch FSM states.
package cpu_pkg;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 19;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch stage.
// Issues one fetch per instruction, holds the result for decode until accepted,
// and honours taken-branch redirects with priority, discarding stale responses.
module fetch_pc_unit
  import cpu_pkg::fetch_state_t;
  import cpu_pkg::FETCH;
  import cpu_pkg::WAIT;
  import cpu_pkg::HOLD;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_next
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

  // Next-state logic; a redirect overrides every other event in each state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    imem_req_d    = 1'b0;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_data_d  = instr_data_q;
    instr_pc_d    = instr_pc_q;

    unique case (state_q)
      FETCH: begin
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
        state_d     = WAIT;
        if (redirect_valid) begin
          // The request going out now targets the old pc; discard its response.
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            instr_data_d  = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        // A coincident handshake still counts as accepted; the target wins for pc.
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          state_d       = FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          pc_d          = pc_q + ADDR_W'(1);
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State, pc and registered outputs; asynchronous reset to the reset vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_data_q  <= instr_data_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr_data  = instr_data_q;
  assign instr_pc    = instr_pc_q;
  assign pc_next     = instr_pc_q + ADDR_W'(1);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: transaction-level reference model,
// directed scenarios and a randomized phase with variable memory latency.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [18:0] redirect_pc;
  logic        imem_req;
  logic [18:0] imem_addr;
  logic        imem_rvalid;
  logic [18:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [18:0] instr_data;
  logic [18:0] instr_pc;
  logic [18:0] pc_next;

  // Second instance with the top-of-memory reset vector.
  logic        b_redirect_valid;
  logic [18:0] b_redirect_pc;
  logic        b_req;
  logic [18:0] b_addr;
  logic        b_rvalid;
  logic [18:0] b_rdata;
  logic        b_valid;
  logic        b_ready;
  logic [18:0] b_data;
  logic [18:0] b_pc;
  logic [18:0] b_next;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .pc_next        (pc_next)
  );

  fetch_pc_unit #(.RESET_PC(19'h7FFFF)) dut_top (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (b_redirect_valid),
    .redirect_pc    (b_redirect_pc),
    .imem_req       (b_req),
    .imem_addr      (b_addr),
    .imem_rvalid    (b_rvalid),
    .imem_rdata     (b_rdata),
    .instr_valid    (b_valid),
    .instr_ready    (b_ready),
    .instr_data     (b_data),
    .instr_pc       (b_pc),
    .pc_next        (b_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Instruction memory contents are a fixed function of the address.
  function automatic logic [18:0] memf(input logic [18:0] a);
    logic [18:0] t;
    t = a * 19'd5;
    return t ^ 19'h2A5A5;
  endfunction

  // Reference model: transaction view of the fetch stage.
  logic [18:0] m_pc, m_addr, m_data, m_ipc;
  logic        m_busy, m_stale, m_hold, m_req;
  int          cyc;

  task automatic model_reset();
    m_pc = 19'h0; m_addr = 19'h0; m_data = 19'h0; m_ipc = 19'h0;
    m_busy = 0; m_stale = 0; m_hold = 0; m_req = 0;
  endtask

  task automatic model_edge();
    logic idle;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    idle  = !m_busy && !m_hold;
    m_req = 0;
    if (idle) begin
      m_req  = 1;
      m_addr = m_pc;
      m_busy = 1;
      if (redirect_valid) begin
        m_pc    = redirect_pc;
        m_stale = 1;
      end
    end else if (m_busy) begin
      if (redirect_valid) begin
        m_pc = redirect_pc;
        if (imem_rvalid) begin
          m_busy  = 0;
          m_stale = 0;
        end else begin
          m_stale = 1;
        end
      end else if (imem_rvalid) begin
        m_busy = 0;
        if (m_stale) begin
          m_stale = 0;
        end else begin
          m_hold = 1;
          m_data = imem_rdata;
          m_ipc  = m_pc;
        end
      end
    end else if (redirect_valid || instr_ready) begin
      m_hold = 0;
      m_pc   = redirect_valid ? redirect_pc : m_pc + 19'd1;
    end
  endtask

  // Stimulus knobs and bench-side memories.
  bit          rnd_mode = 0, lat_rand = 0, spur_en = 0;
  int          lat = 1, p_redir = 0, p_nr = 0;
  logic        ready_val = 1;
  bit          f_redir_wait = 0, f_redir_rv = 0;
  logic [18:0] f_pc;
  bit          assert_pending = 0, rel_pending = 0;
  bit          mp = 0, bp = 0;
  int          mcnt;
  logic [18:0] maddr, baddr;

  logic [18:0] req_log[$];
  logic [18:0] acc_pc_log[$];
  logic [18:0] acc_nx_log[$];
  int          req_cnt = 0;
  int          t_req0 = -1, t_val0 = -1;
  bit          b_req0_done = 0, b_seen = 0, b_addr_done = 0;

  task automatic drive();
    if (rel_pending) begin
      rst_n = 1'b1;
      rel_pending = 0;
    end
    if (assert_pending) begin
      rst_n = 1'b0;
      assert_pending = 0;
      model_reset();
    end
    // Memory A
    imem_rvalid = 1'b0;
    imem_rdata  = 19'($urandom);
    if (!rst_n) begin
      mp = 0;
    end else begin
      if (mp) begin
        mcnt--;
        if (mcnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(maddr);
          mp = 0;
        end
      end else if (spur_en && !m_busy && $urandom_range(0, 9) == 0) begin
        imem_rvalid = 1'b1;
      end
      if (imem_req) begin
        mp    = 1;
        mcnt  = lat_rand ? int'($urandom_range(1, 4)) : lat;
        maddr = imem_addr;
      end
    end
    // Redirect and ready
    redirect_valid = 1'b0;
    redirect_pc    = 19'($urandom);
    if (f_redir_wait && m_busy && !m_stale && !imem_rvalid) begin
      redirect_valid = 1'b1;
      redirect_pc    = f_pc;
      f_redir_wait   = 0;
    end
    if (f_redir_rv && m_busy && !m_stale && imem_rvalid) begin
      redirect_valid = 1'b1;
      redirect_pc    = f_pc;
      f_redir_rv     = 0;
    end
    if (rnd_mode && $urandom_range(0, 99) < p_redir) begin
      redirect_valid = 1'b1;
      if ($urandom_range(0, 3) == 0) redirect_pc = 19'h7FFFF;
    end
    instr_ready = rnd_mode ? ($urandom_range(0, 99) >= p_nr) : ready_val;
    if (rst_n && instr_valid && instr_ready) begin
      acc_pc_log.push_back(instr_pc);
      acc_nx_log.push_back(pc_next);
    end
    // Memory B, fixed one-cycle latency
    b_rvalid = 1'b0;
    b_rdata  = 19'h0;
    if (!rst_n) begin
      bp = 0;
    end else begin
      if (bp) begin
        b_rvalid = 1'b1;
        b_rdata  = memf(baddr);
        bp = 0;
      end
      if (b_req) begin
        bp    = 1;
        baddr = b_addr;
      end
    end
  endtask

  task automatic compare(input bit at_edge);
    logic [18:0] nx;
    if (!rst_n) begin
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 19'h0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_data", instr_data, 19'h0);
      chk("rst_pc", instr_pc, 19'h0);
      chk("rst_pc_next", pc_next, 19'h1);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_b_addr", b_addr, 19'h7FFFF);
      return;
    end
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("instr_valid", instr_valid, m_hold);
    if (m_hold) begin
      nx = m_ipc + 19'd1;
      chk("instr_data", instr_data, m_data);
      chk("instr_pc", instr_pc, m_ipc);
      chk("pc_next", pc_next, nx);
      chk("data_vs_mem", instr_data, memf(instr_pc));
    end
    if (at_edge) begin
      if (imem_req) begin
        req_log.push_back(imem_addr);
        req_cnt++;
        if (t_req0 < 0) t_req0 = cyc;
      end
      if (instr_valid && t_val0 < 0) t_val0 = cyc;
      if (b_req && !b_req0_done) begin
        chk("b_first_addr", b_addr, 19'h7FFFF);
        b_req0_done = 1;
      end
      if (b_req && b_seen && !b_addr_done) begin
        chk("b_wrap_addr", b_addr, 19'h0);
        b_addr_done = 1;
      end
      if (b_valid && !b_seen) begin
        chk("b_instr_pc", b_pc, 19'h7FFFF);
        chk("b_pc_next", b_next, 19'h0);
        chk("b_data", b_data, memf(19'h7FFFF));
        b_seen = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    if (!rst_n) begin
      #1 compare(0);
    end
    @(posedge clk);
    model_edge();
    #1 compare(1);
  endtask

  task automatic clear_logs();
    req_log.delete();
    acc_pc_log.delete();
    acc_nx_log.delete();
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!instr_valid && k < 30) begin
      step();
      k++;
    end
    chk(name, instr_valid, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] sd, sp;
    int rc, k;
    rst_n = 1'b0; redirect_valid = 0; redirect_pc = 0; imem_rvalid = 0; imem_rdata = 0;
    instr_ready = 1; b_redirect_valid = 0; b_redirect_pc = 0; b_rvalid = 0; b_rdata = 0;
    b_ready = 1; cyc = 0;
    model_reset();
    repeat (3) step();
    rel_pending = 1;

    // Reset then back-to-back fetches, 1-cycle memory, decode always ready.
    repeat (14) step();
    chk("t1_req0", req_log.size() > 0 ? req_log[0] : 19'h5A5A5, 19'h0);
    chk("t1_req1", req_log.size() > 1 ? req_log[1] : 19'h5A5A5, 19'h1);
    chk("t1_req2", req_log.size() > 2 ? req_log[2] : 19'h5A5A5, 19'h2);
    chk("t1_pc0", acc_pc_log.size() > 0 ? acc_pc_log[0] : 19'h5A5A5, 19'h0);
    chk("t1_pc1", acc_pc_log.size() > 1 ? acc_pc_log[1] : 19'h5A5A5, 19'h1);
    chk("t1_pc2", acc_pc_log.size() > 2 ? acc_pc_log[2] : 19'h5A5A5, 19'h2);
    chk("t1_nx0", acc_nx_log.size() > 0 ? acc_nx_log[0] : 19'h5A5A5, 19'h1);
    chk("t1_nx1", acc_nx_log.size() > 1 ? acc_nx_log[1] : 19'h5A5A5, 19'h2);
    chk("t1_nx2", acc_nx_log.size() > 2 ? acc_nx_log[2] : 19'h5A5A5, 19'h3);
    chk("t1_latency", 32'(t_val0 - t_req0), 32'd2);

    // Decode stalls in HOLD for five cycles.
    ready_val = 0;
    wait_valid("t2_reach_hold");
    sd = instr_data; sp = instr_pc; rc = req_cnt;
    repeat (5) begin
      step();
      chk("t2_valid_stable", instr_valid, 1);
      chk("t2_data_stable", instr_data, sd);
      chk("t2_pc_stable", instr_pc, sp);
    end
    chk("t2_no_req", req_cnt, rc);

    // Redirect while waiting on a 3-cycle memory.
    ready_val = 1; lat = 3; f_pc = 19'h00100; f_redir_wait = 1;
    k = 0;
    while (f_redir_wait && k < 40) begin step(); k++; end
    chk("t3_redirect_taken", f_redir_wait, 0);
    clear_logs();
    repeat (20) step();
    chk("t3_addr", req_log.size() > 0 ? req_log[0] : 19'h5A5A5, 19'h00100);
    chk("t3_pc", acc_pc_log.size() > 0 ? acc_pc_log[0] : 19'h5A5A5, 19'h00100);

    // Redirect coincident with the response.
    lat = 2; f_pc = 19'h12345; f_redir_rv = 1;
    k = 0;
    while (f_redir_rv && k < 40) begin step(); k++; end
    chk("t4_redirect_taken", f_redir_rv, 0);
    chk("t4_no_valid", instr_valid, 0);
    clear_logs();
    repeat (12) step();
    chk("t4_addr", req_log.size() > 0 ? req_log[0] : 19'h5A5A5, 19'h12345);
    chk("t4_pc", acc_pc_log.size() > 0 ? acc_pc_log[0] : 19'h5A5A5, 19'h12345);

    // Asynchronous reset while holding an instruction.
    ready_val = 0; lat = 1;
    wait_valid("t6_reach_hold");
    assert_pending = 1;
    step();
    chk("t6_valid_low", instr_valid, 0);
    step();
    rel_pending = 1;
    clear_logs();
    ready_val = 1;
    repeat (10) step();
    chk("t6_addr", req_log.size() > 0 ? req_log[0] : 19'h5A5A5, 19'h0);

    // Top-of-memory reset vector instance.
    chk("t5_b_seen", b_seen, 1);
    chk("t5_b_wrap", b_addr_done, 1);

    // Randomized traffic.
    rnd_mode = 1; lat_rand = 1; spur_en = 1; p_redir = 10; p_nr = 30;
    repeat (3000) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
